// File: rtl/c1581_fast_serial_host.sv
// c1581_fast_serial_host: host-side fast-serial byte transceiver for the 1581 burst-mode IEC path
//   clk, reset                     16 MHz clock, asynchronous active-high reset
//   ce                             single-cycle bit-timing enable
//   dir                            1 = host transmits, 0 = host receives
//   tx_data, tx_valid, tx_ready    outgoing byte handshake, sent MSB first
//   rx_data, rx_valid, rx_timeout  received byte, update pulse, partial-byte discard pulse
//   busy                           a byte is in flight
//   iec_data_i/o, iec_fclk_i/o     open-collector fast bus (drive 0 pulls low, 1 releases)
module c1581_fast_serial_host #(
  parameter int CNT_HALF   = 4,
  parameter int RX_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       dir,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_timeout,
  output logic       busy,
  input  logic       iec_data_i,
  input  logic       iec_fclk_i,
  output logic       iec_data_o,
  output logic       iec_fclk_o
);
  localparam logic [1:0] IDLE = 2'd0, TX_LOW = 2'd1, TX_HIGH = 2'd2, RX = 2'd3;
  localparam logic [7:0] HC_LAST = 8'(CNT_HALF - 1);
  localparam logic [15:0] TC_LAST = 16'(RX_TIMEOUT - 1);
  logic [1:0] state, state_n;
  logic [7:0] hc, hc_n, sh, sh_n, rx_data_n;
  logic [2:0] bc, bc_n;
  logic [15:0] tc, tc_n;
  logic fs1, fs2, fs3, ds1, ds2, rise, rd;
  logic rx_valid_n, rx_timeout_n, abort, half_done, tx_n;
  assign tx_ready = (state == IDLE) & dir & ~reset;
  // the byte in flight no longer matches the requested direction
  assign abort = (state != IDLE) & (dir ^ (state != RX));
  assign half_done = ce & (hc == HC_LAST);
  assign tx_n = (state_n == TX_LOW) | (state_n == TX_HIGH);
  always_comb begin
    state_n = state;
    hc_n = hc;
    bc_n = bc;
    tc_n = tc;
    sh_n = sh;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    rx_timeout_n = 1'b0;
    if (abort) begin
      state_n = IDLE;
      hc_n = '0;
      bc_n = '0;
      tc_n = '0;
      sh_n = '0;
    end else begin
      case (state)
        IDLE: begin
          // enter receive only once the synchronised FCLK has settled high, so our
          // own FCLK release at the end of a transmit is never taken as a drive edge
          if (!dir && fs1 && fs2 && fs3) state_n = RX;
          else if (dir && tx_valid) begin
            state_n = TX_LOW;
            sh_n = tx_data;
            bc_n = '0;
            hc_n = '0;
          end
        end
        TX_LOW: begin
          hc_n = half_done ? 8'd0 : ce ? hc + 8'd1 : hc;
          state_n = half_done ? TX_HIGH : TX_LOW;
        end
        TX_HIGH: begin
          hc_n = half_done ? 8'd0 : ce ? hc + 8'd1 : hc;
          if (half_done) begin
            // bc wraps 7 -> 0 on the last bit, leaving the counter clear for busy
            bc_n = bc + 3'd1;
            sh_n = sh << 1;
            state_n = (bc == 3'd7) ? IDLE : TX_LOW;
          end
        end
        default: begin
          if (rise) begin
            sh_n = {sh[6:0], rd};
            bc_n = bc + 3'd1;
            tc_n = '0;
            if (bc == 3'd7) begin
              rx_data_n = {sh[6:0], rd};
              rx_valid_n = 1'b1;
            end
          end else if (ce && bc != 3'd0) begin
            tc_n = (tc == TC_LAST) ? 16'd0 : tc + 16'd1;
            if (tc == TC_LAST) begin
              bc_n = '0;
              sh_n = '0;
              rx_timeout_n = 1'b1;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hc <= '0;
      bc <= '0;
      tc <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_timeout <= 1'b0;
      busy <= 1'b0;
      iec_data_o <= 1'b1;
      iec_fclk_o <= 1'b1;
      {fs1, fs2, fs3, ds1, ds2} <= '1;
      rise <= 1'b0;
      rd <= 1'b1;
    end else begin
      state <= state_n;
      hc <= hc_n;
      bc <= bc_n;
      tc <= tc_n;
      sh <= sh_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_timeout <= rx_timeout_n;
      busy <= (state_n != IDLE) | (bc_n != 3'd0);
      iec_fclk_o <= state_n != TX_LOW;
      iec_data_o <= tx_n ? sh_n[7] : 1'b1;
      {fs1, fs2, fs3} <= {iec_fclk_i, fs1, fs2};
      {ds1, ds2} <= {iec_data_i, ds1};
      // registered edge pulse with its matching data sample
      rise <= fs2 & ~fs3;
      rd <= ds2;
    end
  end
endmodule

// File: tb/tb_c1581_fast_serial_host.sv
// tb_c1581_fast_serial_host: self-checking bench for c1581_fast_serial_host
module tb_c1581_fast_serial_host;
  localparam int CH = 4;
  localparam int RT = 4095;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, dir = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic tx_ready, rx_valid, rx_timeout, busy, iec_data_o, iec_fclk_o, iec_data_i, iec_fclk_i;
  logic peer_fclk = 1'b1, peer_data = 1'b1;
  logic watch_rel = 1'b0;
  int ce_div = 1, ce_cnt = 0;
  int n_cmp = 0, n_bad = 0, n_valid = 0, n_to = 0, rel_bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  typedef struct {
    logic [7:0] d;
    int div;
    logic [7:0] exp_bits;
    int exp_rises;
    int exp_ticks;
    int exp_hi;
  } tx_vec_t;
  tx_vec_t tv[5];
  assign iec_fclk_i = iec_fclk_o & peer_fclk;
  assign iec_data_i = iec_data_o & peer_data;
  c1581_fast_serial_host #(.CNT_HALF(CH), .RX_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .ce(ce), .dir(dir),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_timeout(rx_timeout), .busy(busy),
    .iec_data_i(iec_data_i), .iec_fclk_i(iec_fclk_i),
    .iec_data_o(iec_data_o), .iec_fclk_o(iec_fclk_o)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    ce = (ce_cnt == 0);
    ce_cnt = (ce_cnt + 1) % ce_div;
  end
  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      n_valid++;
      got_q.push_back(rx_data);
    end
    if (rx_timeout) n_to++;
    if (watch_rel && (iec_fclk_o !== 1'b1 || iec_data_o !== 1'b1)) rel_bad++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic set_dir(input logic d);
    @(negedge clk);
    dir = d;
    repeat (6) @(negedge clk);
  endtask
  task automatic tx_byte(input logic [7:0] d, output logic [7:0] bits, output int rises,
                         output int ticks, output int hi_min, output int hi_max,
                         output logic [1:0] first, output logic done);
    int hw;
    logic prev;
    bits = '0;
    rises = 0;
    ticks = 0;
    hi_min = 32'h7fffffff;
    hi_max = 0;
    hw = 0;
    done = 1'b0;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    first = {iec_fclk_o, iec_data_o};
    prev = iec_fclk_o;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (ce) ticks++;
      #1;
      if ((!iec_fclk_o && prev) || tx_ready) begin
        hi_min = (hw < hi_min) ? hw : hi_min;
        hi_max = (hw > hi_max) ? hw : hi_max;
      end
      if (iec_fclk_o && !prev) begin
        bits = {bits[6:0], iec_data_o};
        rises++;
        hw = 0;
      end
      if (iec_fclk_o) hw++;
      prev = iec_fclk_o;
      if (tx_ready) begin
        done = 1'b1;
        break;
      end
    end
  endtask
  // peer shifts nbits of b MSB first; lat = posedges after the final rise until rx_valid
  task automatic rx_send(input logic [7:0] b, input int nbits, input int ph, output int lat);
    lat = -1;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      peer_data = b[i];
      peer_fclk = 1'b0;
      repeat (ph) @(negedge clk);
      peer_fclk = 1'b1;
      for (int k = 0; k < ph + 3; k++) begin
        @(posedge clk);
        #1;
        if (rx_valid && lat < 0 && i == 8 - nbits) lat = k;
      end
    end
  endtask
  initial begin
    logic [7:0] bits, b;
    logic [15:0] bits16;
    logic [1:0] first;
    logic done, prev;
    int rises, ticks, hi_min, hi_max, lat, hw, ready_cnt, bad_w, idx, nv0, nt0, dv, ph;
    int hws[$];
    tv[0] = '{8'hA5, 16, 8'hA5, 8, 16 * CH, CH * 16};
    tv[1] = '{8'h00, 1, 8'h00, 8, 16 * CH, CH * 1};
    tv[2] = '{8'hFF, 3, 8'hFF, 8, 16 * CH, CH * 3};
    tv[3] = '{8'h3C, 1, 8'h3C, 8, 16 * CH, CH * 1};
    tv[4] = '{8'h81, 2, 8'h81, 8, 16 * CH, CH * 2};
    repeat (3) @(negedge clk);
    check("rst_fclk_o", iec_fclk_o, 1);
    check("rst_data_o", iec_data_o, 1);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);
    for (int v = 0; v < 5; v++) begin
      ce_div = tv[v].div;
      tx_byte(tv[v].d, bits, rises, ticks, hi_min, hi_max, first, done);
      check($sformatf("tx%0d_done", v), done, 1);
      check($sformatf("tx%0d_first", v), first, {1'b0, tv[v].d[7]});
      check($sformatf("tx%0d_bits", v), bits, tv[v].exp_bits);
      check($sformatf("tx%0d_rises", v), rises, tv[v].exp_rises);
      check($sformatf("tx%0d_ticks", v), ticks, tv[v].exp_ticks);
      check($sformatf("tx%0d_hi_min", v), hi_min, tv[v].exp_hi);
      check($sformatf("tx%0d_hi_max", v), hi_max, tv[v].exp_hi);
      check($sformatf("tx%0d_data_rel", v), iec_data_o, 1);
    end
    // back-to-back: 0x00 then 0xFF with tx_valid held
    ce_div = 2;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    bits16 = '0;
    rises = 0;
    hw = 0;
    ready_cnt = 0;
    done = 1'b0;
    prev = iec_fclk_o;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      #1;
      if (!iec_fclk_o && prev) hws.push_back(hw);
      if (iec_fclk_o && !prev) begin
        bits16 = {bits16[14:0], iec_data_o};
        rises++;
        hw = 0;
      end
      if (tx_ready && rises == 16) begin
        tx_valid = 1'b0;
        hws.push_back(hw);
        done = 1'b1;
        break;
      end
      if (tx_ready) ready_cnt++;
      if (iec_fclk_o) hw++;
      prev = iec_fclk_o;
    end
    bad_w = 0;
    foreach (hws[i]) if (i != 7 && hws[i] != CH * 2) bad_w++;
    check("b2b_done", done, 1);
    check("b2b_bits", bits16, 16'h00FF);
    check("b2b_rises", rises, 16);
    check("b2b_ready_gap", ready_cnt, 1);
    check("b2b_npulses", hws.size(), 16);
    check("b2b_hi_widths", bad_w, 0);
    check("b2b_gap_width", (hws.size() > 7) ? hws[7] : -1, CH * 2 + 1);
    // basic receive
    ce_div = 1;
    set_dir(1'b0);
    check("rx_tx_ready", tx_ready, 0);
    nv0 = n_valid;
    watch_rel = 1'b1;
    rx_send(8'h3C, 8, 4, lat);
    repeat (2) @(negedge clk);
    watch_rel = 1'b0;
    check("rx_latency", lat, 3);
    check("rx_data_3c", rx_data, 8'h3C);
    check("rx_nvalid", n_valid - nv0, 1);
    check("rx_outputs_held", rel_bad, 0);
    // receive timeout after 3 bits, then a full byte
    nv0 = n_valid;
    nt0 = n_to;
    rx_send(8'hA0, 3, 4, lat);
    idx = -1;
    for (int j = 4 + 3; j < 6000; j++) begin
      @(posedge clk);
      #1;
      if (rx_timeout) begin
        idx = j;
        break;
      end
    end
    check("to_edge_index", idx, 3 + RT);
    @(negedge clk);
    check("to_npulse", n_to - nt0, 1);
    check("to_no_valid", n_valid - nv0, 0);
    check("to_rx_data_kept", rx_data, 8'h3C);
    check("to_busy_rx", busy, 1);
    rx_send(8'h81, 8, 3, lat);
    repeat (2) @(negedge clk);
    check("to_next_latency", lat, 3);
    check("to_next_data", rx_data, 8'h81);
    check("to_next_nvalid", n_valid - nv0, 1);
    // abort transmit on direction change during bit 4
    nt0 = n_to;
    set_dir(1'b1);
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    rises = 0;
    prev = iec_fclk_o;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (iec_fclk_o && !prev) rises++;
      prev = iec_fclk_o;
      if (rises == 3 && !iec_fclk_o) break;
    end
    check("ab_pre_fclk", iec_fclk_o, 0);
    check("ab_pre_data", iec_data_o, 0);
    nv0 = n_valid;
    @(negedge clk);
    dir = 1'b0;
    @(posedge clk);
    #1;
    check("ab_fclk_rel", iec_fclk_o, 1);
    check("ab_data_rel", iec_data_o, 1);
    check("ab_busy", busy, 0);
    check("ab_tx_ready", tx_ready, 0);
    repeat (10) @(negedge clk);
    check("ab_no_valid", n_valid - nv0, 0);
    check("ab_no_timeout", n_to - nt0, 0);
    rx_send(8'hFF, 8, 4, lat);
    repeat (2) @(negedge clk);
    check("ab_rx_latency", lat, 3);
    check("ab_rx_data", rx_data, 8'hFF);
    check("ab_rx_nvalid", n_valid - nv0, 1);
    // randomized mix against the reference model
    got_q.delete();
    exp_q.delete();
    nt0 = n_to;
    for (int it = 0; it < 16; it++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (!dir) set_dir(1'b1);
        dv = $urandom_range(1, 4);
        ce_div = dv;
        tx_byte(b, bits, rises, ticks, hi_min, hi_max, first, done);
        check($sformatf("rnd%0d_tx_bits", it), bits, b);
        check($sformatf("rnd%0d_tx_ticks", it), ticks, 16 * CH);
        check($sformatf("rnd%0d_tx_hi", it), {hi_min[15:0], hi_max[15:0]}, {16'(CH * dv), 16'(CH * dv)});
      end else begin
        if (dir) set_dir(1'b0);
        ce_div = 1;
        ph = $urandom_range(3, 6);
        exp_q.push_back(b);
        rx_send(b, 8, ph, lat);
        repeat (2) @(negedge clk);
        check($sformatf("rnd%0d_rx_lat", it), lat, 3);
        check($sformatf("rnd%0d_rx_qlen", it), got_q.size(), exp_q.size());
        if (got_q.size() > 0 && exp_q.size() > 0)
          check($sformatf("rnd%0d_rx_data", it), got_q.pop_front(), exp_q.pop_front());
      end
    end
    check("rnd_no_timeout", n_to - nt0, 0);
    // asynchronous reset in the middle of a transmit
    set_dir(1'b1);
    ce_div = 1;
    nv0 = n_valid;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_pre_fclk", iec_fclk_o, 0);
    check("ar_pre_data", iec_data_o, 0);
    #2 reset = 1'b1;
    #1;
    check("ar_fclk_rel", iec_fclk_o, 1);
    check("ar_data_rel", iec_data_o, 1);
    check("ar_tx_ready", tx_ready, 0);
    check("ar_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("ar_tx_ready_held", tx_ready, 0);
    check("ar_rx_data", rx_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_ready_after", tx_ready, 1);
    check("ar_no_valid", n_valid - nv0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/c1581_fast_serial_host.md
# c1581_fast_serial_host

Host-side fast-serial (burst mode) transceiver for the 1581 drive's fast IEC path. It models a C128-style CIA serial port in byte-parallel form. In transmit it clocks bytes onto the shared fast-data line with host-generated FCLK pulses. In receive it captures bytes the drive shifts out on SP/CNT. It connects directly to the drive's `iec_data_*` and `iec_fclk_*` pins through the top-level open-collector bus merge, and presents a valid/ready byte interface to the host-side logic.

## Interface
Parameters:
- `CNT_HALF`, default 4: `ce` ticks per FCLK half-period in transmit (range 1..255).
- `RX_TIMEOUT`, default 4095: `ce` ticks without an FCLK rising edge before a partial receive byte is discarded (range 1..65535).

Ports:
- `clk`  in  1  system clock, 16 MHz domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  single-cycle bit-timing enable (1 MHz nominal).
- `dir`  in  1  1 = host transmits, 0 = host receives.
- `tx_data`  in  8  byte to send, MSB first.
- `tx_valid`  in  1  a byte is offered.
- `tx_ready`  out  1  block accepts a byte this cycle.
- `rx_data`  out  8  last received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_timeout`  out  1  one-cycle pulse when a partial byte is discarded.
- `busy`  out  1  a byte is in flight (state ≠ IDLE, or receive bit count ≠ 0).
- `iec_data_i`  in  1  fast-data line level (wired-AND bus).
- `iec_fclk_i`  in  1  fast-clock line level.
- `iec_data_o`  out  1  fast-data drive; 0 pulls the line low, 1 releases it.
- `iec_fclk_o`  out  1  fast-clock drive; 0 pulls the line low, 1 releases it.

## Operation
- **State machine:** IDLE, TX_LOW, TX_HIGH, RX.
- **Counters:** 8-bit half-period counter `hc`, 3-bit bit counter `bc`, 16-bit timeout counter `tc`.
- **`tx_ready`** = (state == IDLE) & `dir`. It is combinational. It is 0 in receive and while `reset` is high.
- **Transmit:**
  - IDLE→TX_LOW on `tx_valid & tx_ready`. Latch `tx_data` into the shift register; `bc`=0, `hc`=0.
  - TX_LOW drives `iec_fclk_o`=0 and `iec_data_o`=shreg[7]. Each `ce` increments `hc`. When `hc` reaches CNT_HALF−1 on a `ce`: go to TX_HIGH, `hc`=0.
  - TX_HIGH drives `iec_fclk_o`=1. On the `ce` where `hc` reaches CNT_HALF−1:
    - if `bc`<7: `bc`++, shift left, go to TX_LOW;
    - else go to IDLE and release `iec_data_o` to 1.
  - Data changes only on FCLK falling edges and is stable across rising edges, where the drive samples.
- **Receive:**
  - With `dir`=0 and state IDLE, move to RX. Both outputs are held at 1.
  - `iec_fclk_i` and `iec_data_i` each pass through 2-flop synchronisers. A third flop on FCLK provides edge detection.
  - On a synchronised FCLK rising edge, shift the synchronised data in at the LSB and increment `bc`; `tc`=0.
  - On the 8th edge, register the byte to `rx_data`, pulse `rx_valid`, and set `bc`=0.
  - `tc` counts `ce` while 0<`bc`<8. At RX_TIMEOUT, clear `bc` and the shift register, pulse `rx_timeout`, and keep `rx_data` unchanged.
- **Direction change:** any change of `dir` outside IDLE aborts the byte.
  - The next cycle releases both outputs to 1, clears `bc`/`hc`/`tc`, and returns to IDLE.
  - No `rx_valid` or `rx_timeout` pulse is generated by the abort.
- **Simultaneous events:** on the same cycle, abort takes priority over the 8th RX edge, which takes priority over the timeout.

## Timing
- **Reset values:** `iec_data_o`=1, `iec_fclk_o`=1, `rx_data`=0, `rx_valid`=0, `rx_timeout`=0, `busy`=0, state IDLE, all counters 0.
- **Output registration:** all outputs except `tx_ready` are registered.
- **Transmit latency:** the handshake cycle is N. `iec_fclk_o` falls and bit 7 appears on edge N+1.
- **Transmit byte length:** 16·CNT_HALF `ce` ticks from FCLK first low to final release.
- **Back-to-back transmit:** `tx_ready` is high in the cycle after the final release, so the next byte may start immediately.
- **Receive latency:** `rx_valid` asserts exactly 3 `clk` edges after the edge that first samples the 8th FCLK rise high. It lasts 1 cycle.
- **Receive rate limit:** FCLK high and low phases on input must each be ≥3 `clk` cycles. Shorter pulses are unsupported.
- **Reset mid-byte:** outputs are released asynchronously and no pulses are emitted.

## Test plan
- **Basic transmit:** CNT_HALF=4, `ce` every 16 clk, `dir`=1, send 0xA5. Expect 8 FCLK low/high pulses of 64 clk each. Data sampled at the rises is 1,0,1,0,0,1,0,1. `tx_ready` returns 1 after 1024 clk.
- **Basic receive:** `dir`=0, peer shifts 0x3C MSB first with 8 rises at 4 clk/phase. Expect `rx_valid` pulse 3 clk after the last rise, `rx_data`=0x3C, both outputs held at 1 throughout.
- **Receive timeout:** `dir`=0, peer sends 3 bits then stops. Expect `rx_timeout` pulse after 4095 `ce`, no `rx_valid`, `rx_data` unchanged. A following full byte 0x81 is received correctly.
- **Abort on direction change:** `dir` flipped 1→0 during TX bit 4. Expect outputs at 1 next cycle, `busy`=0, no pulses, and a subsequent receive of 0xFF that succeeds.
- **Back-to-back transmit:** `tx_valid` held with 0x00 then 0xFF. Expect 16 contiguous FCLK pulses with no idle gap beyond 1 clk. Data line low for 8 bits, then high.
- **Asynchronous reset:** `reset` asserted mid-TX, asynchronous to `clk`. Expect immediate `iec_fclk_o`=`iec_data_o`=1 and `tx_ready`=0 while `reset` is high.
